// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared read-1/write port of main memory.
// m1 can lock the port for uninterrupted loader bursts.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_resp_rdata,
  output logic              m0_resp_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic              m1_req_lock,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_resp_rdata,
  output logic              m1_resp_err,

  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,

  output logic [CNT_W-1:0]  m0_grant_cnt,
  output logic [CNT_W-1:0]  m1_grant_cnt
);

  typedef enum logic [1:0] {
    RR0,
    RR1,
    LOCK1
  } state_t;

  state_t state, state_nxt;

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              rd_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RR0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    unique case (state)
      RR0: begin
        if (m0_req_valid) begin
          gnt0 = 1'b1;
        end else if (m1_req_valid) begin
          gnt1 = 1'b1;
        end
      end
      RR1: begin
        if (m1_req_valid) begin
          gnt1 = 1'b1;
        end else if (m0_req_valid) begin
          gnt0 = 1'b1;
        end
      end
      LOCK1: begin
        gnt1 = m1_req_valid;
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
    // nothing is accepted while reset is held
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      state_nxt = RR1;
    end else if (gnt1) begin
      state_nxt = m1_req_lock ? LOCK1 : RR0;
    end
  end

  assign m0_req_ready = gnt0;
  assign m1_req_ready = gnt1;
  assign any_gnt      = gnt0 | gnt1;

  // idle cycles present m0's fields to memory
  assign sel_we    = gnt1 ? m1_req_we    : m0_req_we;
  assign sel_addr  = gnt1 ? m1_req_addr  : m0_req_addr;
  assign sel_wdata = gnt1 ? m1_req_wdata : m0_req_wdata;

  assign in_range = sel_addr < ADDR_W'(DEPTH);
  assign rd_ok    = !sel_we && in_range;

  assign mem_read_address  = sel_addr;
  assign mem_write_address = sel_addr;
  assign mem_write_data    = sel_wdata;
  assign mem_write_enable  = any_gnt && sel_we && in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_resp_valid <= 1'b0;
      m0_resp_err   <= 1'b0;
      m0_resp_rdata <= '0;
      m1_resp_valid <= 1'b0;
      m1_resp_err   <= 1'b0;
      m1_resp_rdata <= '0;
    end else begin
      m0_resp_valid <= gnt0;
      m0_resp_err   <= gnt0 && !in_range;
      m0_resp_rdata <= (gnt0 && rd_ok) ? mem_read_data : '0;
      m1_resp_valid <= gnt1;
      m1_resp_err   <= gnt1 && !in_range;
      m1_resp_rdata <= (gnt1 && rd_ok) ? mem_read_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
    end else begin
      if (gnt0 && (m0_grant_cnt != '1)) begin
        m0_grant_cnt <= m0_grant_cnt + 1'b1;
      end
      if (gnt1 && (m1_grant_cnt != '1)) begin
        m1_grant_cnt <= m1_grant_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus reset/lock sequences.
// A second instance with 2-bit counters exercises saturation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_we;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic        m1_req_valid, m1_req_we, m1_req_lock;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic [31:0] mem_read_data;

  logic        m0_req_ready, m1_req_ready;
  logic        m0_resp_valid, m1_resp_valid;
  logic [31:0] m0_resp_rdata, m1_resp_rdata;
  logic        m0_resp_err, m1_resp_err;
  logic [31:0] mem_read_address, mem_write_address, mem_write_data;
  logic        mem_write_enable;
  logic [15:0] m0_grant_cnt, m1_grant_cnt;

  logic        s_r0, s_r1, s_rv0, s_rv1, s_e0, s_e1, s_we;
  logic [31:0] s_rd0, s_rd1, s_ra, s_wa, s_wd;
  logic [1:0]  s_c0, s_c1;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
    .m0_req_we(m0_req_we), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_resp_valid(m0_resp_valid),
    .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
    .m1_req_we(m1_req_we), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_lock(m1_req_lock),
    .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata),
    .m1_resp_err(m1_resp_err),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable),
    .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt)
  );

  mem_port_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(s_r0),
    .m0_req_we(m0_req_we), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_resp_valid(s_rv0),
    .m0_resp_rdata(s_rd0), .m0_resp_err(s_e0),
    .m1_req_valid(m1_req_valid), .m1_req_ready(s_r1),
    .m1_req_we(m1_req_we), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_lock(m1_req_lock),
    .m1_resp_valid(s_rv1), .m1_resp_rdata(s_rd1),
    .m1_resp_err(s_e1),
    .mem_read_address(s_ra), .mem_read_data(mem_read_data),
    .mem_write_address(s_wa), .mem_write_data(s_wd),
    .mem_write_enable(s_we),
    .m0_grant_cnt(s_c0), .m1_grant_cnt(s_c1)
  );

  // behavioural memory, combinational read
  logic [31:0] bmem [0:2047];
  assign mem_read_data = bmem[mem_read_address[10:0]];
  always @(posedge clk) begin
    if (mem_write_enable) bmem[mem_write_address[10:0]] <= mem_write_data;
  end

  typedef struct {
    logic        m0v, m0we;
    logic [31:0] m0a, m0d;
    logic        m1v, m1we, m1lk;
    logic [31:0] m1a, m1d;
    logic        r0, r1, we;
    logic        rv0, e0;
    logic [31:0] rd0;
    logic        rv1, e1;
    logic [31:0] rd1;
    int          c0, c1;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    m0_req_valid = v.m0v; m0_req_we = v.m0we;
    m0_req_addr  = v.m0a; m0_req_wdata = v.m0d;
    m1_req_valid = v.m1v; m1_req_we = v.m1we; m1_req_lock = v.m1lk;
    m1_req_addr  = v.m1a; m1_req_wdata = v.m1d;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) bmem[i] = 32'hA000_0000 + i;

    //          m0v we a   d             m1v we lk a     d
    //          r0 r1 we  rv0 e0 rd0      rv1 e1 rd1     c0 c1
    tbl[0]  = '{1,0,4,0, 1,0,0,8,0, 1,0,0, 0,0,0, 0,0,0, 0,0};
    tbl[1]  = '{1,0,4,0, 1,0,0,8,0, 0,1,0,
                1,0,32'hA000_0004, 0,0,0, 1,0};
    tbl[2]  = '{1,0,4,0, 1,0,0,8,0, 1,0,0,
                0,0,0, 1,0,32'hA000_0008, 1,1};
    tbl[3]  = '{1,0,4,0, 1,0,0,8,0, 0,1,0,
                1,0,32'hA000_0004, 0,0,0, 2,1};
    tbl[4]  = '{1,0,4,0, 1,0,0,8,0, 1,0,0,
                0,0,0, 1,0,32'hA000_0008, 2,2};
    tbl[5]  = '{1,0,4,0, 1,0,0,8,0, 0,1,0,
                1,0,32'hA000_0004, 0,0,0, 3,2};
    tbl[6]  = '{1,1,10,32'hDEAD_BEEF, 0,0,0,0,0, 1,0,1,
                0,0,0, 1,0,32'hA000_0008, 3,3};
    tbl[7]  = '{1,0,10,0, 0,0,0,0,0, 1,0,0, 1,0,0, 0,0,0, 4,3};
    tbl[8]  = '{0,0,0,0, 0,0,0,0,0, 0,0,0,
                1,0,32'hDEAD_BEEF, 0,0,0, 5,3};
    tbl[9]  = '{1,0,4,0, 1,1,1,0,32'h100, 0,1,1,
                0,0,0, 0,0,0, 5,3};
    tbl[10] = '{1,0,4,0, 1,1,1,1,32'h101, 0,1,1,
                0,0,0, 1,0,0, 5,4};
    tbl[11] = '{1,0,4,0, 1,1,1,2,32'h102, 0,1,1,
                0,0,0, 1,0,0, 5,5};
    tbl[12] = '{1,0,4,0, 1,1,0,3,32'h103, 0,1,1,
                0,0,0, 1,0,0, 5,6};
    tbl[13] = '{1,0,0,0, 0,0,0,0,0, 1,0,0, 0,0,0, 1,0,0, 5,7};
    tbl[14] = '{0,0,0,0, 1,1,0,2048,32'h55, 0,1,0,
                1,0,32'h100, 0,0,0, 6,7};
    tbl[15] = '{0,0,0,0, 1,0,0,4095,0, 0,1,0,
                0,0,0, 1,1,0, 6,8};
    tbl[16] = '{1,0,0,0, 0,0,0,0,0, 1,0,0, 0,0,0, 1,1,0, 6,9};
    tbl[17] = '{0,0,0,0, 0,0,0,0,0, 0,0,0,
                1,0,32'h100, 0,0,0, 7,9};

    // reset with both masters requesting
    rst = 1'b1;
    drive(tbl[0]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_ready0", m0_req_ready, 0);
      chk("rst_ready1", m1_req_ready, 0);
      chk("rst_we", mem_write_enable, 0);
      chk("rst_cnt0", m0_grant_cnt, 0);
      chk("rst_cnt1", m1_grant_cnt, 0);
      chk("rst_rv0", m0_resp_valid, 0);
    end

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i), m0_req_ready, tbl[i].r0);
      chk($sformatf("v%0d_ready1", i), m1_req_ready, tbl[i].r1);
      chk($sformatf("v%0d_we", i), mem_write_enable, tbl[i].we);
      chk($sformatf("v%0d_rv0", i), m0_resp_valid, tbl[i].rv0);
      chk($sformatf("v%0d_err0", i), m0_resp_err, tbl[i].e0);
      chk($sformatf("v%0d_rdata0", i), m0_resp_rdata, tbl[i].rd0);
      chk($sformatf("v%0d_rv1", i), m1_resp_valid, tbl[i].rv1);
      chk($sformatf("v%0d_err1", i), m1_resp_err, tbl[i].e1);
      chk($sformatf("v%0d_rdata1", i), m1_resp_rdata, tbl[i].rd1);
      chk($sformatf("v%0d_cnt0", i), m0_grant_cnt, tbl[i].c0);
      chk($sformatf("v%0d_cnt1", i), m1_grant_cnt, tbl[i].c1);
      if (i == 8) chk("sat_cnt0_after5", s_c0, 3);
      @(posedge clk); #1;
    end
    chk("sat_cnt0_end", s_c0, 3);
    chk("sat_cnt1_end", s_c1, 3);
    chk("mem0_kept", bmem[0], 32'h100);

    // m1 takes the lock, then reset lands mid-lock
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 4;
    m1_req_valid = 1; m1_req_we = 1; m1_req_lock = 1;
    m1_req_addr = 5; m1_req_wdata = 32'h77;
    @(negedge clk);
    chk("lk_ready1", m1_req_ready, 1);
    chk("lk_ready0", m0_req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_ready0", m0_req_ready, 0);
    chk("mr_ready1", m1_req_ready, 0);
    chk("mr_we", mem_write_enable, 0);
    chk("mr_rv1_pending", m1_resp_valid, 1);
    chk("mr_rv0", m0_resp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_rv1_cleared", m1_resp_valid, 0);
    chk("mr_cnt1", m1_grant_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m1_req_we = 0; m1_req_lock = 0;
    @(negedge clk);
    chk("post_rst_ready0", m0_req_ready, 1);
    chk("post_rst_ready1", m1_req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_rr_ready1", m1_req_ready, 1);
    chk("post_rst_rr_ready0", m0_req_ready, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
